uart_tx_mio: RTL and testbench
==============================

# uart_tx_mio

Memory-mapped UART transmitter on the MIO bus peripheral path, alongside the GPIO/counter devices. It consumes CPU store data from the bus `Peripheral_in` word under a decoded write enable, buffers bytes in a small FIFO and serialises them 8N1 on `txd`. It returns a status word to the bus read mux and raises a level interrupt toward the CPU `INT` input when the transmitter drains.

## Interface
- `DEPTH`, default 8: FIFO depth in bytes; power of 2, range 2..8.
- `DEFAULT_DIV`, default 434: bit period in clk cycles after reset (115200 baud at 50 MHz).
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `EN`, in, 1: bus write strobe for this device; one write per cycle it is high.
- `addr`, in, 1: register select. 0 = TX data, 1 = control.
- `P_Data`, in, 32: write data from the bus.
- `rd_data`, out, 32: status word, combinational from registers.
- `txd`, out, 1: serial output, idle high.
- `tx_busy`, out, 1: shifter is not in IDLE.
- `fifo_full`, out, 1: FIFO count equals DEPTH.
- `fifo_empty`, out, 1: FIFO count equals 0.
- `INT`, out, 1: `irq_en & fifo_empty & ~tx_busy`.

## Operation
- **Data write** (`EN=1`, `addr=0`):
  - Not full: push `P_Data[7:0]`; upper bits are ignored.
  - Full: drop the byte and set sticky `overflow`.
  - Full with a pop in the same cycle: push accepted, count unchanged, no overflow.
- **Control write** (`EN=1`, `addr=1`):
  - `divisor <= P_Data[15:0]`; a value of 0 is stored as 1.
  - `irq_en <= P_Data[16]`.
  - `P_Data[17]=1` clears `overflow`. If a data write were somehow simultaneous, clear wins; this cannot happen because only one write occurs per cycle.
- **rd_data layout**:
  - [3:0] count
  - [4] empty
  - [5] full
  - [6] busy
  - [7] overflow
  - [8] irq_en
  - [15:9] 0
  - [31:16] divisor
- **FIFO**: circular buffer with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH; count has width log2(DEPTH)+1.
- **FSM states** IDLE, START, DATA, STOP. A baud counter `bcnt` counts down, and a bit is finished when `bcnt==0`.
  - IDLE: `txd=1`. If the FIFO is not empty, pop the head into the shift register, load `bcnt=divisor-1`, go to START.
  - START: `txd=0`. On `bcnt==0`: reload, `bit_idx=0`, go to DATA.
  - DATA: `txd=shift[0]`, LSB first. On `bcnt==0`: shift right and reload. Go to STOP after bit 7 completes; otherwise increment `bit_idx`.
  - STOP: `txd=1`. On `bcnt==0`: if the FIFO is not empty, pop, reload and go to START directly (back-to-back, no idle bit); else go to IDLE.
- **Divisor change mid-frame**: takes effect at the next reload; the current bit keeps its length.
- **Reset values**:
  - `txd=1`, `tx_busy=0`, `fifo_empty=1`, `fifo_full=0`, `INT=0`.
  - overflow 0, irq_en 0, divisor `DEFAULT_DIV`, pointers and count 0, FSM IDLE.
- **Reset mid-frame**: the frame is aborted, `txd` is 1 from the cycle after reset is sampled, and FIFO contents are discarded.

## Timing
- Data write at edge 0 into an empty FIFO with the FSM idle:
  - count=1 after edge 0.
  - Pop at edge 1; `txd` falls after edge 1.
  - START is observed in cycle 2.
- Every bit is exactly `divisor` clocks. One frame is 10×`divisor` clocks.
- Back-to-back frames have no gap: the next start bit begins the cycle after the last stop-bit cycle.
- Status and `INT` are combinational from registers and reflect a write one cycle after its edge.
- `INT` asserts in the first cycle after the final stop bit when no data remains.
- Pop and push in the same cycle both take effect.

## Test plan
- **Reset**: hold `rst` 2 cycles → `txd=1`, `rd_data=0x01B20010` (divisor 434 = 0x1B2, empty=1), `INT=0`.
- **Single byte**:
  - Stimulus: control write `0x0001_0004` (div=4, irq_en), then data write `0xA5`.
  - Response: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; START begins 2 cycles after the write.
  - `INT` goes 0 then 1 after 40 cycles.
- **Back-to-back**: div=4, write `0x00`, `0xFF`, `0x55` on consecutive cycles → 120 contiguous cycles of framing, stop bit followed immediately by start bit, count returns to 0.
- **Overflow**:
  - Stimulus: div=1000, write 10 bytes.
  - Response: 1 byte popped and 8 held (full=1); 10th write dropped with overflow=1.
  - Control write with bit 17 set → overflow=0, divisor updated.
- **Full push/pop collision**: with the FIFO full, issue a data write in the exact STOP-to-START pop cycle → count stays 8, overflow stays 0, the byte is transmitted last.
- **Mid-frame reset and divisor change**:
  - Assert `rst` during bit 3 → `txd=1` the next cycle, empty=1.
  - Separately, change div 4→8 during DATA → the current bit stays 4 cycles and following bits are 8 cycles.

Source files
------------

// File: rtl/uart_tx_mio.sv
// ---------------------------------------------------------------------------
// uart_tx_mio
// Memory-mapped 8N1 UART transmitter for the MIO peripheral bus.
// CPU stores are captured from the bus write word into a small byte FIFO.
// The FIFO drains through a start/data/stop shifter whose bit period is a
// programmable divisor. A status word is returned to the bus read mux.
// A level interrupt is raised once the transmitter has fully drained.
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of 2, 2..8)
//   DEFAULT_DIV  bit period in clk cycles after reset
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   EN           write strobe for this device
//   addr         0 = TX data register, 1 = control register
//   P_Data       bus write data
//   rd_data      status word {divisor, 7'b0, irq_en, overflow, busy, full,
//                empty, count}
//   txd          serial output, idle high
//   tx_busy      shifter not idle
//   fifo_full    FIFO holds DEPTH bytes
//   fifo_empty   FIFO holds no bytes
//   INT          irq_en & fifo_empty & ~tx_busy
// ---------------------------------------------------------------------------
module uart_tx_mio #(
    parameter int DEPTH       = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        addr,
    input  logic [31:0] P_Data,
    output logic [31:0] rd_data,
    output logic        txd,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        INT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          irq_en_q, irq_en_d;
    logic [15:0]   divisor_q, divisor_d;

    state_e        state_q;
    logic [15:0]   bcnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;

    logic          data_wr, ctrl_wr, push, pop, bit_done;
    logic [15:0]   reload;

    // Control bits above the overflow-clear flag have no function.
    logic          unused_pdata;
    assign unused_pdata = ^P_Data[31:18];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign tx_busy    = (state_q != IDLE);
    assign txd        = txd_q;
    assign INT        = irq_en_q & fifo_empty & ~tx_busy;
    assign rd_data    = {divisor_q, 7'd0, irq_en_q, overflow_q, tx_busy,
                         fifo_full, fifo_empty, 4'(count_q)};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        data_wr    = EN & ~addr;
        ctrl_wr    = EN & addr;
        bit_done   = (bcnt_q == 16'd0);
        reload     = divisor_q - 16'd1;
        // The shifter takes the head byte when idle, or at the end of a stop bit
        // so the next start bit follows with no idle gap.
        pop        = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_done));
        // A simultaneous pop frees a slot, so a write to a full FIFO is still accepted.
        push       = data_wr & (~fifo_full | pop);
        count_d    = count_q + CW'(push) - CW'(pop);

        overflow_d = overflow_q;
        if (data_wr & fifo_full & ~pop)
            overflow_d = 1'b1;
        if (ctrl_wr & P_Data[17])
            overflow_d = 1'b0;

        irq_en_d   = ctrl_wr ? P_Data[16] : irq_en_q;
        divisor_d  = divisor_q;
        if (ctrl_wr)
            divisor_d = (P_Data[15:0] == 16'd0) ? 16'd1 : P_Data[15:0];
    end

    // NOTE: byte storage is not reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= P_Data[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            divisor_q  <= 16'(DEFAULT_DIV);
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            divisor_q  <= divisor_d;
        end
    end

    // Shifter FSM. Each bit lasts divisor cycles: bcnt is loaded with divisor-1
    // and the bit ends in the cycle where it reads zero. A new divisor only
    // takes effect at the next reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            bcnt_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        bcnt_q  <= reload;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bcnt_q    <= reload;
                        bit_idx_q <= 3'd0;
                        txd_q     <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        bcnt_q <= bcnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        bcnt_q  <= reload;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        bcnt_q <= bcnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            bcnt_q  <= reload;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        bcnt_q <= bcnt_q - 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mio.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_mio
// Self-checking bench for uart_tx_mio. Stimulus pushes the frames it expects
// into a queue. Each entry holds the byte, the length of every bit and the
// cycle the start bit must begin. A receiver process watches txd on the falling
// clock edge. It pops an entry on every start bit and compares the waveform
// sample by sample. Status and interrupt checks are made inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_uart_tx_mio;

    logic        clk;
    logic        rst;
    logic        EN;
    logic        addr;
    logic [31:0] P_Data;
    logic [31:0] rd_data;
    logic        txd;
    logic        tx_busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic        INT;

    uart_tx_mio #(.DEPTH(8), .DEFAULT_DIV(434)) dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .addr      (addr),
        .P_Data    (P_Data),
        .rd_data   (rd_data),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .INT       (INT)
    );

    // exp_start: absolute cycle of the first start-bit cycle, -1 = don't care,
    // -2 = must follow the previous frame's stop bit with no gap.
    typedef struct packed {
        logic [7:0]         data;
        logic [9:0][15:0]   len;
        logic signed [31:0] exp_start;
    } frame_t;

    frame_t exp_q[$];
    int     checks  = 0;
    int     errors  = 0;
    int     cyc     = 0;
    int     last_wr = 0;
    logic   mon_en  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus write sampled at the next rising edge; returns just after it.
    task automatic do_write(input logic a, input logic [31:0] d);
        EN     = 1'b1;
        addr   = a;
        P_Data = d;
        @(posedge clk);
        #1;
        EN      = 1'b0;
        addr    = 1'b0;
        P_Data  = 32'd0;
        last_wr = cyc;
    endtask

    // The first n_first bits (start bit first) last l_first cycles, the rest l_rest.
    function automatic frame_t mk(input logic [7:0] d, input int l_first, input int l_rest,
                                  input int n_first, input int st);
        frame_t f;
        f.data      = d;
        f.exp_start = st;
        for (int b = 0; b < 10; b++)
            f.len[b] = (b < n_first) ? 16'(l_first) : 16'(l_rest);
        return f;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((tx_busy || !fifo_empty || exp_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, 32'(n < 20000), 32'd1);
    endtask

    // Serial receiver and scoreboard.
    initial begin : monitor
        frame_t      item;
        logic        prev;
        logic        exp_bit;
        logic [7:0]  rx;
        logic [31:0] errs;
        int          start_cyc;
        int          last_end;
        prev     = 1'b1;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !txd) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
                end else begin
                    item      = exp_q.pop_front();
                    start_cyc = cyc;
                    if (item.exp_start == -2)
                        check("frame_gap", start_cyc, last_end + 1);
                    else if (item.exp_start >= 0)
                        check("frame_start", start_cyc, item.exp_start);
                    errs = 0;
                    rx   = 8'd0;
                    for (int b = 0; b < 10; b++) begin
                        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : item.data[b-1];
                        for (int k = 0; k < int'(item.len[b]); k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (txd !== exp_bit) errs++;
                            if (b >= 1 && b <= 8 && k == int'(item.len[b]) / 2)
                                rx[b-1] = txd;
                        end
                    end
                    last_end = cyc;
                    check("frame_data", {errs[23:0], rx}, {24'd0, item.data});
                end
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        int zeros;
        rst    = 1'b1;
        EN     = 1'b0;
        addr   = 1'b0;
        P_Data = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_txd",    txd,        1);
        check("reset_status", rd_data,    32'h01B2_0010);
        check("reset_int",    INT,        0);
        check("reset_busy",   tx_busy,    0);
        check("reset_full",   fifo_full,  0);
        check("reset_empty",  fifo_empty, 1);

        // Single byte: div 4, irq enabled, upper data bits ignored
        do_write(1'b1, 32'h0001_0004);
        check("int_idle_enabled", INT, 1);
        do_write(1'b0, 32'hFFFF_FFA5);
        c = last_wr;
        exp_q.push_back(mk(8'hA5, 4, 4, 0, c + 1));
        check("single_int_low", INT, 0);
        check("single_status",  rd_data, 32'h0004_0101);
        repeat (40) @(posedge clk);
        #1;
        check("single_int_last_stop", INT, 0);
        @(posedge clk);
        #1;
        check("single_int_done", INT, 1);
        wait_drain("single");

        // Back-to-back frames
        do_write(1'b1, 32'h0000_0004);
        do_write(1'b0, 32'h0000_0000);
        exp_q.push_back(mk(8'h00, 4, 4, 0, last_wr + 1));
        do_write(1'b0, 32'h0000_00FF);
        exp_q.push_back(mk(8'hFF, 4, 4, 0, -2));
        do_write(1'b0, 32'h0000_0055);
        exp_q.push_back(mk(8'h55, 4, 4, 0, -2));
        wait_drain("b2b");
        check("b2b_status", rd_data, 32'h0004_0010);

        // Divisor 4 -> 8 during data bit 2 (frame bit index 3)
        do_write(1'b0, 32'h0000_003C);
        c = last_wr;
        exp_q.push_back(mk(8'h3C, 4, 8, 4, c + 1));
        repeat (13) @(posedge clk);
        #1;
        do_write(1'b1, 32'h0000_0008);
        wait_drain("divchg");
        check("divchg_status", rd_data, 32'h0008_0010);

        // Overflow: div 1000, ten writes, the tenth is dropped
        do_write(1'b1, 32'h0000_03E8);
        for (int i = 0; i < 10; i++) begin
            do_write(1'b0, 32'(8'h10 + i));
            if (i == 0)
                exp_q.push_back(mk(8'h10, 1000, 4, 1, last_wr + 1));
            else if (i < 9)
                exp_q.push_back(mk(8'(8'h10 + i), 4, 4, 0, -2));
        end
        check("ovf_status", rd_data, 32'h03E8_00E8);
        do_write(1'b1, 32'h0002_0004);
        check("ovf_cleared", rd_data, 32'h0004_0068);
        wait_drain("ovf");
        check("ovf_idle", rd_data, 32'h0004_0010);

        // Full FIFO with a write landing exactly on the STOP-to-START pop
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_write(1'b1, 32'h0000_0004);
        for (int i = 0; i < 9; i++) begin
            do_write(1'b0, 32'(8'h20 + i));
            exp_q.push_back(mk(8'(8'h20 + i), 4, 4, 0, (i == 0) ? last_wr + 1 : -2));
        end
        check("collide_full_before", rd_data, 32'h0004_0068);
        repeat (32) @(posedge clk);
        #1;
        do_write(1'b0, 32'h0000_0029);
        exp_q.push_back(mk(8'h29, 4, 4, 0, -2));
        check("collide_status", rd_data, 32'h0004_0068);
        wait_drain("collide");
        check("collide_idle", rd_data, 32'h0004_0010);

        // Reset during data bit 3 aborts the frame
        mon_en = 1'b0;
        do_write(1'b0, 32'h0000_0000);
        repeat (17) @(posedge clk);
        #1;
        check("txd_before_reset", txd, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("txd_after_reset",    txd,     1);
        check("status_after_reset", rd_data, 32'h01B2_0010);
        zeros = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1) zeros++;
        end
        check("txd_idle_after_reset", zeros, 0);
        mon_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
